rv32i_dmem_bridge: RTL and testbench

Memory-side responder for the core's data load/store port. Accepts one request at a time (mem_op_e, ram_mask_e, 32-bit address/data) and executes it on a 16-bit halfword-addressed external RAM bus, such as the Pocket PSRAM/SDRAM arbiter port. Word accesses are split into two beats, and byte/half accesses are lane-aligned. Load data is returned right-aligned and unextended; the core applies reg_mask_e sign/zero extension.

---
 rtl/rv32i_pkg.sv | 28 ++
 rtl/rv32i_dmem_bridge_if.sv | 38 +++
 rtl/rv32i_dmem_lane_align.sv | 41 ++++
 rtl/rv32i_dmem_bridge.sv | 142 ++++++++++++++
 tb/tb_rv32i_dmem_bridge.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store types used by the core and the data-memory bridge.
package rv32i;

  typedef enum logic {
    MEM_LOAD  = 1'b0,
    MEM_STORE = 1'b1
  } mem_op_e;

  typedef enum logic [1:0] {
    MASK_B = 2'd0,
    MASK_H = 2'd1,
    MASK_W = 2'd2
  } ram_mask_e;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_MISALIGN,
    ERR_TIMEOUT
  } dmem_err_e;

  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_LO,
    DMEM_HI,
    DMEM_DONE
  } dmem_state_e;

endpackage

// File: rtl/rv32i_dmem_bridge_if.sv
// Core load/store port plus 16-bit halfword RAM bus; slave = bridge view, master = core/RAM view.
interface rv32i_dmem_bridge_if #(
  parameter int ADDR_W = 22
);
  import rv32i::*;

  logic              req_valid;
  logic              req_ready;
  mem_op_e           req_op;
  ram_mask_e         req_mask;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;

  logic              rsp_valid;
  dmem_err_e         rsp_err;
  logic [31:0]       rsp_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_be;
  logic [15:0]       mem_wdata;
  logic              mem_ack;
  logic [15:0]       mem_rdata;

  modport slave (
    input  req_valid, req_op, req_mask, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_op, req_mask, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

endinterface

// File: rtl/rv32i_dmem_lane_align.sv
// Combinational lane steering: byte enables, write halfword, alignment check and read merge.
module rv32i_dmem_lane_align
  import rv32i::*;
(
  input  ram_mask_e   mask,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic        beat_hi,
  input  logic [15:0] mem_rdata,
  input  logic [15:0] lo_half,
  output logic [1:0]  be,
  output logic [15:0] wdata16,
  output logic        misalign,
  output logic [31:0] rdata
);

  always_comb begin
    be       = 2'b11;
    wdata16  = beat_hi ? wdata[31:16] : wdata[15:0];
    misalign = 1'b0;
    rdata    = 32'h0;
    unique case (mask)
      MASK_B: begin
        be      = addr_lo[0] ? 2'b10 : 2'b01;
        wdata16 = {2{wdata[7:0]}};
        rdata   = {24'h0, (addr_lo[0] ? mem_rdata[15:8] : mem_rdata[7:0])};
      end
      MASK_H: begin
        misalign = addr_lo[0];
        rdata    = {16'h0, mem_rdata};
      end
      MASK_W: begin
        misalign = |addr_lo;
        rdata    = beat_hi ? {mem_rdata, lo_half} : {16'h0, mem_rdata};
      end
      // Encoding 3 is not a legal access size; reject it rather than touch memory.
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32i_dmem_bridge.sv
// Executes one core load/store on a 16-bit RAM bus; B/H rsp at T+2, W at T+3 with zero-wait acks.
// One request in flight: req_ready only in IDLE; rsp_valid is a one-cycle pulse with no backpressure.
module rv32i_dmem_bridge
  import rv32i::*;
#(
  parameter int ADDR_W  = 22,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  rv32i_dmem_bridge_if.slave  bus
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  dmem_state_e       state_q, state_d;
  mem_op_e           op_q, op_d;
  ram_mask_e         mask_q, mask_d;
  logic [ADDR_W:0]   addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [15:0]       lo_q, lo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  dmem_err_e         err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              in_idle, beat_act, beat_hi, expire;
  ram_mask_e         al_mask;
  logic [1:0]        al_addr, al_be;
  logic [15:0]       al_wdata;
  logic              al_misalign;
  logic [31:0]       al_rdata;

  assign in_idle  = (state_q == DMEM_IDLE);
  assign beat_hi  = (state_q == DMEM_HI);
  assign beat_act = (state_q == DMEM_LO) || beat_hi;

  // In IDLE the aligner looks at the incoming request so misalignment is known at accept.
  assign al_mask = in_idle ? bus.req_mask       : mask_q;
  assign al_addr = in_idle ? bus.req_addr[1:0]  : addr_q[1:0];

  rv32i_dmem_lane_align u_align (
    .mask      (al_mask),
    .addr_lo   (al_addr),
    .wdata     (wdata_q),
    .beat_hi   (beat_hi),
    .mem_rdata (bus.mem_rdata),
    .lo_half   (lo_q),
    .be        (al_be),
    .wdata16   (al_wdata),
    .misalign  (al_misalign),
    .rdata     (al_rdata)
  );

  assign expire = (TIMEOUT != 0) && beat_act && !bus.mem_ack &&
                  (32'(cnt_q) == 32'(TIMEOUT - 1));

  assign bus.req_ready = in_idle;
  assign bus.rsp_valid = (state_q == DMEM_DONE);
  assign bus.rsp_err   = err_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.mem_req   = beat_act;
  assign bus.mem_we    = beat_act && (op_q == MEM_STORE);
  assign bus.mem_addr  = beat_act ? (addr_q[ADDR_W:1] + ADDR_W'(beat_hi)) : '0;
  assign bus.mem_be    = beat_act ? al_be : 2'b00;
  assign bus.mem_wdata = bus.mem_we ? al_wdata : 16'h0;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    mask_d  = mask_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      DMEM_IDLE: begin
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          mask_d  = bus.req_mask;
          addr_d  = bus.req_addr[ADDR_W:0];
          wdata_d = bus.req_wdata;
          cnt_d   = '0;
          if (al_misalign) begin
            state_d = DMEM_DONE;
            err_d   = ERR_MISALIGN;
            rdata_d = 32'h0;
          end else begin
            state_d = DMEM_LO;
          end
        end
      end
      DMEM_LO, DMEM_HI: begin
        if (bus.mem_ack) begin
          cnt_d = '0;
          if (!beat_hi && (mask_q == MASK_W)) begin
            state_d = DMEM_HI;
            lo_d    = bus.mem_rdata;
          end else begin
            state_d = DMEM_DONE;
            err_d   = ERR_NONE;
            rdata_d = (op_q == MEM_LOAD) ? al_rdata : 32'h0;
          end
        end else if (expire) begin
          state_d = DMEM_DONE;
          err_d   = ERR_TIMEOUT;
          rdata_d = 32'h0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DMEM_DONE: state_d = DMEM_IDLE;
      default:   state_d = DMEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= DMEM_IDLE;
      op_q    <= MEM_LOAD;
      mask_q  <= MASK_B;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      err_q   <= ERR_NONE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_rv32i_dmem_bridge.sv
// Randomized load/store traffic against a byte-level memory model with per-beat ack delays.
module tb_rv32i_dmem_bridge;
  import rv32i::*;

  localparam int AW = 22;
  localparam int TO = 4;

  typedef struct {
    logic [AW-1:0] hw;
    logic [1:0]    be;
    logic [15:0]   wd;
  } beat_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  rv32i_dmem_bridge_if #(.ADDR_W(AW)) bus ();

  rv32i_dmem_bridge #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] ref_mem [int];   // what memory should hold
  logic [7:0] ram     [int];   // what the emulated RAM actually holds

  function automatic logic [7:0] init_byte(input int a);
    return 8'(a * 37 + 11);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [AW:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_byte(int'(a));
  endfunction

  function automatic logic [7:0] ram_rd(input logic [AW:0] a);
    return ram.exists(int'(a)) ? ram[int'(a)] : init_byte(int'(a));
  endfunction

  function automatic logic [15:0] ref_hw(input logic [AW-1:0] h);
    return {ref_rd({h, 1'b1}), ref_rd({h, 1'b0})};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic poke_hw(input logic [AW-1:0] h, input logic [15:0] v);
    ram[int'({h, 1'b0})]     = v[7:0];
    ram[int'({h, 1'b1})]     = v[15:8];
    ref_mem[int'({h, 1'b0})] = v[7:0];
    ref_mem[int'({h, 1'b1})] = v[15:8];
  endtask

  function automatic int pick_delay();
    int r;
    r = int'($urandom_range(0, 19));
    if (r == 0) return 6;
    if (r == 1) return 3;
    return int'($urandom_range(0, 2));
  endfunction

  // abort_at > 0 pulses reset at that cycle after accept instead of waiting for a response.
  task automatic run_txn(input mem_op_e op, input ram_mask_e mask, input logic [31:0] addr,
                         input logic [31:0] wdata, input int d0, input int d1, input int abort_at);
    beat_t         bt[2];
    int            d[2];
    int            nb, nack, exp_lat, b, k;
    logic          mis, seen;
    logic [AW-1:0] hw;
    logic [31:0]   exp_rd;
    dmem_err_e     exp_err;
    logic [15:0]   lanes;

    hw   = addr[AW:1];
    d[0] = d0;
    d[1] = d1;
    mis  = ((mask == MASK_H) && addr[0]) || ((mask == MASK_W) && (addr[1:0] != 2'b00));
    nb   = mis ? 0 : ((mask == MASK_W) ? 2 : 1);
    bt[0].hw = hw;
    bt[0].be = (mask == MASK_B) ? (addr[0] ? 2'b10 : 2'b01) : 2'b11;
    bt[0].wd = (mask == MASK_B) ? {2{wdata[7:0]}} : wdata[15:0];
    bt[1].hw = hw + AW'(1);
    bt[1].be = 2'b11;
    bt[1].wd = wdata[31:16];

    exp_err = mis ? ERR_MISALIGN : ERR_NONE;
    exp_lat = 1;
    nack    = 0;
    for (int i = 0; i < nb; i++) begin
      if (exp_err == ERR_NONE) begin
        if (d[i] >= TO) begin
          exp_lat += TO;
          exp_err = ERR_TIMEOUT;
        end else begin
          exp_lat += d[i] + 1;
          nack++;
        end
      end
    end
    exp_rd = 32'h0;
    if (op == MEM_LOAD && exp_err == ERR_NONE) begin
      case (mask)
        MASK_B:  exp_rd = {24'h0, ref_rd({hw, addr[0]})};
        MASK_H:  exp_rd = {16'h0, ref_hw(hw)};
        default: exp_rd = {ref_hw(hw + AW'(1)), ref_hw(hw)};
      endcase
    end

    @(negedge clk);
    check_eq("req_ready idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_mask  = mask;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;

    b = 0;
    k = 0;
    seen = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 16'($urandom);
      if (n == abort_at) begin
        check_eq("abort in flight", 32'(bus.mem_req), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("abort mem_req", 32'(bus.mem_req), 32'd0);
        check_eq("abort req_ready", 32'(bus.req_ready), 32'd1);
        check_eq("abort rsp_valid", 32'(bus.rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
          @(negedge clk);
          check_eq("no rsp after abort", 32'(bus.rsp_valid), 32'd0);
        end
        return;
      end
      if (bus.rsp_valid) begin
        seen = 1'b1;
        check_eq("latency", 32'(n), 32'(exp_lat));
        check_eq("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
        check_eq("rsp_rdata", bus.rsp_rdata, exp_rd);
        check_eq("beats acked", 32'(b), 32'(nack));
        check_eq("mem_req in done", 32'(bus.mem_req), 32'd0);
        break;
      end
      if (bus.mem_req) begin
        if (k == 0) begin
          if (b < nb) begin
            check_eq("beat addr", 32'(bus.mem_addr), 32'(bt[b].hw));
            check_eq("beat be", 32'(bus.mem_be), 32'(bt[b].be));
            check_eq("beat we", 32'(bus.mem_we), 32'(op == MEM_STORE));
            if (op == MEM_STORE) begin
              lanes = {{8{bt[b].be[1]}}, {8{bt[b].be[0]}}};
              check_eq("beat wdata", 32'(bus.mem_wdata & lanes), 32'(bt[b].wd & lanes));
            end
          end else begin
            check_eq("extra beat", 32'(b), 32'(nb));
          end
        end
        if (b < nb && k == d[b]) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = {ram_rd({bus.mem_addr, 1'b1}), ram_rd({bus.mem_addr, 1'b0})};
          if (bus.mem_we) begin
            if (bus.mem_be[0]) ram[int'({bus.mem_addr, 1'b0})] = bus.mem_wdata[7:0];
            if (bus.mem_be[1]) ram[int'({bus.mem_addr, 1'b1})] = bus.mem_wdata[15:8];
          end
          if (op == MEM_STORE) begin
            if (bt[b].be[0]) ref_mem[int'({bt[b].hw, 1'b0})] = bt[b].wd[7:0];
            if (bt[b].be[1]) ref_mem[int'({bt[b].hw, 1'b1})] = bt[b].wd[15:8];
          end
          b++;
          k = 0;
        end else begin
          k++;
        end
      end
      @(negedge clk);
    end
    check_eq("rsp seen", 32'(seen), 32'd1);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check_eq("rsp one-cycle", 32'(bus.rsp_valid), 32'd0);
    check_eq("ready after rsp", 32'(bus.req_ready), 32'd1);
    check_eq("rdata hold", bus.rsp_rdata, exp_rd);
    check_eq("err hold", 32'(bus.rsp_err), 32'(exp_err));
  endtask

  initial begin
    mem_op_e   op;
    ram_mask_e mk;

    bus.req_valid = 1'b0;
    bus.req_op    = MEM_LOAD;
    bus.req_mask  = MASK_B;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'h0;

    #12;
    check_eq("reset req_ready", 32'(bus.req_ready), 32'd1);
    check_eq("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("reset rsp_err", 32'(bus.rsp_err), 32'(ERR_NONE));
    check_eq("reset rsp_rdata", bus.rsp_rdata, 32'h0);
    check_eq("reset mem_req", 32'(bus.mem_req), 32'd0);
    check_eq("reset mem_we", 32'(bus.mem_we), 32'd0);
    check_eq("reset mem_addr", 32'(bus.mem_addr), 32'd0);
    check_eq("reset mem_be", 32'(bus.mem_be), 32'd0);
    check_eq("reset mem_wdata", 32'(bus.mem_wdata), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_txn(MEM_STORE, MASK_B, 32'h0000_0005, 32'h1234_56AB, 0, 0, 0);
    poke_hw(AW'('h80), 16'hBEEF);
    poke_hw(AW'('h81), 16'hDEAD);
    run_txn(MEM_LOAD, MASK_W, 32'h0000_0100, 32'h0, 0, 0, 0);
    check_eq("LW 0x100 value", bus.rsp_rdata, 32'hDEAD_BEEF);
    run_txn(MEM_LOAD, MASK_H, 32'h0000_0003, 32'h0, 0, 0, 0);
    run_txn(MEM_LOAD, MASK_W, 32'h0000_0002, 32'h0, 0, 0, 0);
    poke_hw(AW'('h3), 16'h80FF);
    run_txn(MEM_LOAD, MASK_B, 32'h0000_0007, 32'h0, 0, 0, 0);
    check_eq("LBU 0x7 value", bus.rsp_rdata, 32'h0000_0080);
    run_txn(MEM_STORE, MASK_W, 32'h0000_0040, 32'hCAFE_F00D, 9, 0, 0);
    run_txn(MEM_STORE, MASK_W, 32'h0000_0040, 32'hCAFE_F00D, 3, 0, 0);
    run_txn(MEM_STORE, MASK_W, 32'h0000_0020, 32'h5566_7788, 0, 9, 0);
    run_txn(MEM_LOAD, MASK_W, 32'h0000_0020, 32'h0, 1, 2, 0);
    run_txn(MEM_LOAD, MASK_H, 32'h0000_0042, 32'h0, 0, 0, 0);
    run_txn(MEM_LOAD, MASK_W, 32'h007F_FFFC, 32'h0, 0, 0, 0);
    run_txn(MEM_STORE, MASK_W, 32'hFF80_0014, 32'hA5A5_0F0F, 0, 0, 0);
    run_txn(MEM_LOAD, MASK_W, 32'h0000_0014, 32'h0, 0, 0, 0);
    run_txn(MEM_STORE, MASK_W, 32'h0000_0030, 32'h1357_9BDF, 0, 50, 3);
    run_txn(MEM_LOAD, MASK_B, 32'h0000_0031, 32'h0, 0, 0, 0);
    run_txn(MEM_LOAD, MASK_W, 32'h0000_0030, 32'h0, 0, 0, 0);

    for (int t = 0; t < 150; t++) begin
      op = ($urandom_range(0, 1) == 0) ? MEM_LOAD : MEM_STORE;
      case ($urandom_range(0, 2))
        0:       mk = MASK_B;
        1:       mk = MASK_H;
        default: mk = MASK_W;
      endcase
      run_txn(op, mk, $urandom & 32'hFF80_003F, $urandom, pick_delay(), pick_delay(), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
